// File: rtl/motion_bbox.sv
// motion_bbox: per-frame bounding box and foreground pixel count of the eroded motion mask.
// Define MOTION_BBOX_LATENCY_COMP_EN to shift coordinates back by the eroder latency (H_DELAY/V_DELAY).
module motion_bbox #(
   parameter int H_IMG_RES  = 640,
   parameter int V_IMG_RES  = 480,
   parameter int MIN_PIXELS = 16
`ifdef MOTION_BBOX_LATENCY_COMP_EN
   ,
   parameter int H_DELAY    = 3,
   parameter int V_DELAY    = 3
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hpos,
   input  logic [10:0] vpos,
   input  logic        in_pix,
   input  logic        res_ack,
   output logic        res_valid,
   output logic        res_found,
   output logic [10:0] bb_xmin,
   output logic [10:0] bb_xmax,
   output logic [10:0] bb_ymin,
   output logic [10:0] bb_ymax,
   output logic [18:0] pix_count,
   output logic        overrun
);

   localparam logic [10:0] H_RES    = 11'(H_IMG_RES);
   localparam logic [10:0] V_RES    = 11'(V_IMG_RES);
   localparam logic [10:0] H_LAST   = 11'(H_IMG_RES - 1);
   localparam logic [10:0] V_LAST   = 11'(V_IMG_RES - 1);
   localparam logic [18:0] MIN_CNT  = 19'(MIN_PIXELS);
   localparam logic [10:0] MIN_INIT = 11'h7FF;
   localparam logic [18:0] CNT_MAX  = 19'h7FFFF;

   typedef enum logic [1:0] {
      UNARMED = 2'd0,
      ACCUM   = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        active;
   logic        arm_pix;
   logic        eof_pix;
   logic        take_pix;
   logic        load_init;
   logic        frame_found;

   logic [10:0] pix_x;
   logic [10:0] pix_y;

   logic [10:0] acc_xmin;
   logic [10:0] acc_xmax;
   logic [10:0] acc_ymin;
   logic [10:0] acc_ymax;
   logic [18:0] acc_cnt;

   logic [10:0] base_xmin;
   logic [10:0] base_xmax;
   logic [10:0] base_ymin;
   logic [10:0] base_ymax;
   logic [18:0] base_cnt;

   logic [10:0] nxt_xmin;
   logic [10:0] nxt_xmax;
   logic [10:0] nxt_ymin;
   logic [10:0] nxt_ymax;
   logic [18:0] nxt_cnt;

   // Frame arming and end-of-frame always use the raw raster counters.
   assign active  = (hpos < H_RES) && (vpos < V_RES);
   assign arm_pix = active && (hpos == 11'd0) && (vpos == 11'd0);
   assign eof_pix = active && (hpos == H_LAST) && (vpos == V_LAST);

`ifdef MOTION_BBOX_LATENCY_COMP_EN
   localparam logic [10:0] H_DLY  = 11'(H_DELAY);
   localparam logic [10:0] V_DLY  = 11'(V_DELAY);
   localparam logic [10:0] H_WRAP = 11'(H_IMG_RES - H_DELAY);
   localparam logic [10:0] V_WRAP = 11'(V_IMG_RES - V_DELAY);

   always_comb begin
      pix_x = (hpos < H_DLY) ? (hpos + H_WRAP) : (hpos - H_DLY);
      pix_y = (vpos < V_DLY) ? (vpos + V_WRAP) : (vpos - V_DLY);
   end
`else
   assign pix_x = hpos;
   assign pix_y = vpos;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= UNARMED;
      end else begin
         state <= state_nxt;
      end
   end

   // REPORT accumulates its own pixel into fresh values so back-to-back frames lose nothing.
   always_comb begin
      state_nxt = state;
      take_pix  = 1'b0;
      load_init = 1'b0;
      unique case (state)
         UNARMED: begin
            if (arm_pix) begin
               take_pix  = 1'b1;
               load_init = 1'b1;
               state_nxt = eof_pix ? REPORT : ACCUM;
            end
         end
         ACCUM, REPORT: begin
            take_pix  = active;
            load_init = arm_pix || (state == REPORT);
            state_nxt = eof_pix ? REPORT : ACCUM;
         end
         default: begin
            state_nxt = UNARMED;
         end
      endcase
   end

   always_comb begin
      base_xmin = load_init ? MIN_INIT : acc_xmin;
      base_xmax = load_init ? 11'd0    : acc_xmax;
      base_ymin = load_init ? MIN_INIT : acc_ymin;
      base_ymax = load_init ? 11'd0    : acc_ymax;
      base_cnt  = load_init ? 19'd0    : acc_cnt;

      nxt_xmin = base_xmin;
      nxt_xmax = base_xmax;
      nxt_ymin = base_ymin;
      nxt_ymax = base_ymax;
      nxt_cnt  = base_cnt;

      if (take_pix && in_pix) begin
         if (pix_x < base_xmin) nxt_xmin = pix_x;
         if (pix_x > base_xmax) nxt_xmax = pix_x;
         if (pix_y < base_ymin) nxt_ymin = pix_y;
         if (pix_y > base_ymax) nxt_ymax = pix_y;
         if (base_cnt != CNT_MAX) nxt_cnt = base_cnt + 19'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_xmin <= MIN_INIT;
         acc_xmax <= 11'd0;
         acc_ymin <= MIN_INIT;
         acc_ymax <= 11'd0;
         acc_cnt  <= 19'd0;
      end else begin
         acc_xmin <= nxt_xmin;
         acc_xmax <= nxt_xmax;
         acc_ymin <= nxt_ymin;
         acc_ymax <= nxt_ymax;
         acc_cnt  <= nxt_cnt;
      end
   end

   assign frame_found = (acc_cnt >= MIN_CNT);

   // Handshake: the record is held while res_valid=1; res_ack sampled with res_valid=1
   // retires it and clears overrun. A REPORT always wins over a coincident ack
   // (res_valid stays 1, overrun cleared); a REPORT onto an unacked record sets overrun.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_found <= 1'b0;
         bb_xmin   <= 11'd0;
         bb_xmax   <= 11'd0;
         bb_ymin   <= 11'd0;
         bb_ymax   <= 11'd0;
         pix_count <= 19'd0;
         overrun   <= 1'b0;
      end else if (state == REPORT) begin
         res_valid <= 1'b1;
         res_found <= frame_found;
         bb_xmin   <= frame_found ? acc_xmin : 11'd0;
         bb_xmax   <= frame_found ? acc_xmax : 11'd0;
         bb_ymin   <= frame_found ? acc_ymin : 11'd0;
         bb_ymax   <= frame_found ? acc_ymax : 11'd0;
         pix_count <= acc_cnt;
         if (res_valid) begin
            overrun <= !res_ack;
         end
      end else if (res_valid && res_ack) begin
         res_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule

// File: doc/motion_bbox.md
Name: motion_bbox

Overview:
- Consumes the binary motion mask produced by the 5x5 morphological eroder, sampled against the same hpos/vpos raster counters.
- Accumulates, per frame, the bounding box and the foreground pixel count of the eroded mask.
- At end of frame, latches the results into a held output record with a valid/ack handshake, read by the host/UART reporting logic.
- Sits directly downstream of the eroder in the node pipeline.

Parameters:
- H_IMG_RES, 640, active pixels per line.
- V_IMG_RES, 480, active lines per frame.
- MIN_PIXELS, 16, minimum foreground count for a frame to report a detection.
- H_DELAY, 3, horizontal latency of the upstream eroder in pixels; used only with the optional feature.
- V_DELAY, 3, vertical latency of the upstream eroder in lines; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- hpos  in  11  raster column counter; values >= H_IMG_RES are blanking.
- vpos  in  11  raster line counter; values >= V_IMG_RES are blanking.
- in_pix  in  1  eroded mask pixel for the current hpos/vpos.
- res_ack  in  1  consumer acknowledge; clears res_valid.
- res_valid  out  1  result record is held and valid.
- res_found  out  1  pix_count >= MIN_PIXELS.
- bb_xmin  out  11  leftmost foreground column.
- bb_xmax  out  11  rightmost foreground column.
- bb_ymin  out  11  top foreground line.
- bb_ymax  out  11  bottom foreground line.
- pix_count  out  19  foreground pixels in the frame; saturates at 2^19-1.
- overrun  out  1  sticky; a result was overwritten before it was acked.

Behaviour:
- Reset: all reset actions occur on the clk edge with rst_n=0.
  - All outputs go to 0.
  - FSM goes to UNARMED.
  - Accumulators are initialised: xmin=ymin=11'h7FF, xmax=ymax=0, count=0.
- Active pixel: hpos<H_IMG_RES and vpos<V_IMG_RES. Inputs outside the active region are ignored entirely.
- FSM UNARMED:
  - Waits for an active pixel at hpos=0, vpos=0.
  - On that pixel, loads the initial accumulator values, includes that pixel, and moves to ACCUM.
  - A reset mid-frame therefore discards the partial frame; no result is produced for it.
- FSM ACCUM:
  - On each active pixel with in_pix=1: xmin=min(xmin,x), xmax=max(xmax,x), ymin=min(ymin,y), ymax=max(ymax,y), count+=1 (saturating).
  - On the active pixel hpos=H_IMG_RES-1, vpos=V_IMG_RES-1 (end of frame), go to REPORT. That pixel is included in the result.
- FSM REPORT (exactly one cycle), then ACCUM re-armed for the next frame at hpos=0, vpos=0:
  - Copy the accumulators to the outputs.
  - res_found=(count>=MIN_PIXELS).
  - If res_found=0, bb_* outputs are forced to 0; pix_count is still reported.
  - Set res_valid=1.
- Latency: res_valid and the record update on the clock edge following the end-of-frame pixel's sampling edge (1 cycle).
- The record is stable while res_valid=1, except when it is overwritten by a new REPORT.
- Handshake:
  - res_ack=1 while res_valid=1 clears res_valid on the next edge and clears overrun.
  - res_ack while res_valid=0 has no effect.
- Overrun: REPORT while res_valid=1 and res_ack=0 overwrites the record, keeps res_valid=1, and sets overrun=1.
- Simultaneous REPORT and res_ack: the new record wins, res_valid stays 1, and overrun is cleared (not set).
- hpos/vpos jumps that skip pixel (0,0) while UNARMED: the FSM stays UNARMED.
- In ACCUM, a frame restart at (0,0) without an end-of-frame pixel reinitialises the accumulators; the aborted frame is not reported.
- Width rules:
  - Comparisons are unsigned on 11 bits.
  - count is 19 bits; 640x480=307200 fits.

Optional Feature:
- Macro: MOTION_BBOX_LATENCY_COMP_EN.
- Defined: coordinates are corrected for the eroder latency before min/max.
  - x=hpos-H_DELAY; if hpos<H_DELAY, x=hpos+H_IMG_RES-H_DELAY.
  - y=vpos-V_DELAY with the same wrap using V_IMG_RES.
  - Frame detection (arming and end-of-frame) still uses the raw hpos/vpos.
- Undefined: x=hpos, y=vpos; H_DELAY and V_DELAY are unused.

Test Plan:
- Single-pixel frame: a frame with in_pix=1 only at (100,50) -> res_valid=1 one cycle after (639,479); pix_count=1, res_found=0, bb_*=0.
- Rectangle frame: a 20x10 block at x=200..219, y=100..109 -> xmin=200, xmax=219, ymin=100, ymax=109, pix_count=200, res_found=1.
- Overrun: two frames, no ack -> second record visible, overrun=1; then ack -> res_valid=0, overrun=0.
- Ack coincident with the REPORT edge -> res_valid stays 1, overrun=0, new record visible.
- Reset mid-frame: rst_n low at vpos=200, released, remainder of the frame streamed -> no result until the following full frame completes.
- MOTION_BBOX_LATENCY_COMP_EN defined, H_DELAY=V_DELAY=3: pixel at raw (2,1) -> bb_xmin=639, bb_ymin=478 (wrap), with MIN_PIXELS=1.
